// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the program-RAM port arbiter.
// Contents: arbiter state encoding, default RAM geometry, burst counter width.
package ram_arb_pkg;

  localparam int unsigned ADR_W_DEF     = 6;
  localparam int unsigned DAT_W_DEF     = 16;
  localparam int unsigned BURST_MAX_DEF = 8;
  // Wide enough for the largest legal BURST_MAX (255).
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_GRANT0 = 2'd2,
    ST_GRANT1 = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ram_arb_burst_cnt.sv
// Saturating burst-length counter for the RAM arbiter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_ce         clock enable
//   i_clr        clear (wins over increment)
//   i_inc        count one accepted access
//   o_at_max_c   count, including this cycle's increment, has reached MAX
module ram_arb_burst_cnt
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX = BURST_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ce,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max_c
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] r_cnt;

  // Count accepted accesses, saturating at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX_V)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Looks ahead by the current access so a burst hands over right after its MAX-th access.
  assign o_at_max_c = (r_cnt == MAX_V) || (i_inc && ((r_cnt + CNT_W'(1)) == MAX_V));

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port program RAM between the boot loader (absolute owner
// while boot=1), the CPU core (requester 0) and the debug reader (requester 1).
// Round-robin arbitration with a bounded burst length under contention.
// Macro ARB_FIXED_PRIO_EN: requester 0 has fixed priority and is never
// pre-empted; without it, round robin with a pointer.
// Ports:
//   clk, rst, ce                 clock, async active-high reset, clock enable
//   boot, bl_*                   boot loader ownership and RAM access
//   rN_req/rw/adr/din            requester N access (N=0,1)
//   rN_gnt, rN_rvalid            registered grant and read-valid pulse
//   rd_data                      registered read data shared by both requesters
//   ram_rw/enable/adr/in         combinational RAM port drive
//   ram_out                      RAM read data, valid the cycle after the enable
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADR_W     = ADR_W_DEF,
  parameter int unsigned DAT_W     = DAT_W_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             boot,
  input  logic             bl_rw,
  input  logic             bl_en,
  input  logic [ADR_W-1:0] bl_adr,
  input  logic [DAT_W-1:0] bl_din,
  input  logic             r0_req,
  input  logic             r0_rw,
  input  logic [ADR_W-1:0] r0_adr,
  input  logic [DAT_W-1:0] r0_din,
  output logic             r0_gnt,
  output logic             r0_rvalid,
  input  logic             r1_req,
  input  logic             r1_rw,
  input  logic [ADR_W-1:0] r1_adr,
  input  logic [DAT_W-1:0] r1_din,
  output logic             r1_gnt,
  output logic             r1_rvalid,
  output logic [DAT_W-1:0] rd_data,
  output logic             ram_rw,
  output logic             ram_enable,
  output logic [ADR_W-1:0] ram_adr,
  output logic [DAT_W-1:0] ram_in,
  input  logic [DAT_W-1:0] ram_out
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic             w_rd_acc;
  logic             w_at_max;
  logic             w_clr;
  logic             r_p1_vld;
  logic             r_p1_id;
  logic             r_rv0;
  logic             r_rv1;
  logic [DAT_W-1:0] r_rd_data;
`ifndef ARB_FIXED_PRIO_EN
  logic             r_rr;
  logic             w_rr_nxt;
`endif

  assign w_acc0   = r_gnt0 & r0_req & ce;
  assign w_acc1   = r_gnt1 & r1_req & ce;
  assign w_acc    = w_acc0 | w_acc1;
  assign w_rd_acc = (w_acc0 & ~r0_rw) | (w_acc1 & ~r1_rw);
  assign w_clr    = (w_state_nxt != r_state);

  ram_arb_burst_cnt #(
    .MAX(BURST_MAX)
  ) u_burst_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_ce      (ce),
    .i_clr     (w_clr),
    .i_inc     (w_acc),
    .o_at_max_c(w_at_max)
  );

  // State register; grants are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      r_rr    <= 1'b0;
`endif
    end else if (ce) begin
      r_state <= w_state_nxt;
      r_gnt0  <= (w_state_nxt == ST_GRANT0);
      r_gnt1  <= (w_state_nxt == ST_GRANT1);
`ifndef ARB_FIXED_PRIO_EN
      r_rr    <= w_rr_nxt;
`endif
    end
  end

  // Next-state selection; boot overrides everything.
  always_comb begin
    w_state_nxt = r_state;
`ifndef ARB_FIXED_PRIO_EN
    w_rr_nxt    = r_rr;
`endif
    if (boot) begin
      w_state_nxt = ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT: w_state_nxt = ST_IDLE;
        ST_IDLE: begin
`ifdef ARB_FIXED_PRIO_EN
          if (r0_req)      w_state_nxt = ST_GRANT0;
          else if (r1_req) w_state_nxt = ST_GRANT1;
`else
          if (r0_req && r1_req) w_state_nxt = r_rr ? ST_GRANT1 : ST_GRANT0;
          else if (r0_req)      w_state_nxt = ST_GRANT0;
          else if (r1_req)      w_state_nxt = ST_GRANT1;
`endif
        end
        ST_GRANT0: begin
          if (!r0_req) w_state_nxt = ST_IDLE;
`ifndef ARB_FIXED_PRIO_EN
          else if (w_at_max && r1_req) w_state_nxt = ST_GRANT1;
`endif
        end
        ST_GRANT1: begin
          if (!r1_req)                 w_state_nxt = ST_IDLE;
          else if (w_at_max && r0_req) w_state_nxt = ST_GRANT0;
        end
        default: w_state_nxt = ST_BOOT;
      endcase
    end
`ifndef ARB_FIXED_PRIO_EN
    // Leaving a grant for any reason hands preference to the other requester.
    if ((r_state == ST_GRANT0) && (w_state_nxt != ST_GRANT0)) w_rr_nxt = 1'b1;
    if ((r_state == ST_GRANT1) && (w_state_nxt != ST_GRANT1)) w_rr_nxt = 1'b0;
`endif
  end

  // RAM port mux driven from the current owner.
  always_comb begin
    ram_enable = 1'b0;
    ram_rw     = 1'b0;
    ram_adr    = '0;
    ram_in     = '0;
    case (r_state)
      ST_BOOT: begin
        ram_enable = bl_en;
        ram_rw     = bl_rw;
        ram_adr    = bl_adr;
        ram_in     = bl_din;
      end
      ST_GRANT0: begin
        ram_enable = r0_req;
        ram_rw     = r0_rw & r0_req;
        ram_adr    = r0_adr;
        ram_in     = r0_din;
      end
      ST_GRANT1: begin
        ram_enable = r1_req;
        ram_rw     = r1_rw & r1_req;
        ram_adr    = r1_adr;
        ram_in     = r1_din;
      end
      default: ;
    endcase
  end

  // Two-stage read-valid pipeline tagged with the requester id; survives boot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_vld  <= 1'b0;
      r_p1_id   <= 1'b0;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      r_rd_data <= '0;
    end else if (ce) begin
      r_p1_vld <= w_rd_acc;
      r_p1_id  <= w_acc1;
      r_rv0    <= r_p1_vld & ~r_p1_id;
      r_rv1    <= r_p1_vld & r_p1_id;
      if (r_p1_vld) r_rd_data <= ram_out;
    end
  end

  assign r0_gnt    = r_gnt0;
  assign r1_gnt    = r_gnt1;
  assign r0_rvalid = r_rv0;
  assign r1_rvalid = r_rv1;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against an ownership/scoreboard reference model.
module tb_ram_port_arbiter;

  localparam int ADR_W = 6;
  localparam int DAT_W = 16;
  localparam int BM    = 8;

  logic             clk, rst, ce, boot, bl_rw, bl_en;
  logic [ADR_W-1:0] bl_adr, r0_adr, r1_adr, ram_adr;
  logic [DAT_W-1:0] bl_din, r0_din, r1_din, rd_data, ram_in, ram_out;
  logic             r0_req, r0_rw, r0_gnt, r0_rvalid;
  logic             r1_req, r1_rw, r1_gnt, r1_rvalid;
  logic             ram_rw, ram_enable;
  logic             mem_init;

  ram_port_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .ce(ce), .boot(boot),
    .bl_rw(bl_rw), .bl_en(bl_en), .bl_adr(bl_adr), .bl_din(bl_din),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_adr(r0_adr), .r0_din(r0_din),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_adr(r1_adr), .r1_din(r1_din),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rd_data(rd_data), .ram_rw(ram_rw), .ram_enable(ram_enable),
    .ram_adr(ram_adr), .ram_in(ram_in), .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DAT_W-1:0] init_val(int i);
    if (i == 3) return 16'h1234;
    return DAT_W'((i * 257) ^ 23130);
  endfunction

  // Physical RAM: single port, read data registered, gated by ce.
  logic [DAT_W-1:0] ram_mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_val(i);
    end else if (ce && ram_enable) begin
      if (ram_rw) ram_mem[ram_adr] <= ram_in;
      else        ram_out <= ram_mem[ram_adr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM, accesses in the current grant,
  // preferred requester, and a queue of expected read returns.
  typedef struct {
    int               due;
    int               id;
    logic [DAT_W-1:0] data;
  } rd_t;

  bit               m_in_boot;
  int               m_own, m_run, m_pref, m_tick;
  logic [DAT_W-1:0] m_rd;
  logic [DAT_W-1:0] m_mem [64];
  rd_t              m_q[$];
  logic             e_en, e_rw;
  logic [ADR_W-1:0] e_adr;
  logic [DAT_W-1:0] e_in;
  logic             obs_acc0, obs_acc1;

  task automatic model_reset();
    m_in_boot = 1'b1;
    m_own     = -1;
    m_run     = 0;
    m_pref    = 0;
    m_rd      = '0;
    m_q.delete();
  endtask

  task automatic model_mux();
    e_en = 1'b0; e_rw = 1'b0; e_adr = '0; e_in = '0;
    if (m_in_boot) begin
      e_en = bl_en; e_rw = bl_rw; e_adr = bl_adr; e_in = bl_din;
    end else if (m_own == 0) begin
      e_en = r0_req; e_rw = r0_rw & r0_req; e_adr = r0_adr; e_in = r0_din;
    end else if (m_own == 1) begin
      e_en = r1_req; e_rw = r1_rw & r1_req; e_adr = r1_adr; e_in = r1_din;
    end
  endtask

  task automatic check_outputs();
    bit ev0, ev1;
    model_mux();
    ev0 = (m_q.size() > 0) && (m_q[0].due == m_tick) && (m_q[0].id == 0);
    ev1 = (m_q.size() > 0) && (m_q[0].due == m_tick) && (m_q[0].id == 1);
    check("gnt0", 32'(r0_gnt), 32'(!m_in_boot && m_own == 0));
    check("gnt1", 32'(r1_gnt), 32'(!m_in_boot && m_own == 1));
    check("rvalid0", 32'(r0_rvalid), 32'(ev0));
    check("rvalid1", 32'(r1_rvalid), 32'(ev1));
    if (ev0 || ev1) check("rd_data", 32'(rd_data), 32'(m_rd));
    check("ram_enable", 32'(ram_enable), 32'(e_en));
    check("ram_rw", 32'(ram_rw), 32'(e_rw));
    if (e_en) begin
      check("ram_adr", 32'(ram_adr), 32'(e_adr));
      if (e_rw) check("ram_in", 32'(ram_in), 32'(e_in));
    end
  endtask

  task automatic model_step();
    int acc, new_own, o;
    bit new_boot, oreq, oth;
    if (!ce) return;
    model_mux();
    acc = 0;
    if (!m_in_boot && m_own == 0 && r0_req) begin
      acc = 1;
      if (!r0_rw) m_q.push_back('{m_tick + 2, 0, m_mem[r0_adr]});
    end
    if (!m_in_boot && m_own == 1 && r1_req) begin
      acc = 1;
      if (!r1_rw) m_q.push_back('{m_tick + 2, 1, m_mem[r1_adr]});
    end
    if (e_en && e_rw) m_mem[e_adr] = e_in;
    new_boot = m_in_boot;
    new_own  = m_own;
    if (boot) begin
      new_boot = 1'b1;
      new_own  = -1;
    end else if (m_in_boot) begin
      new_boot = 1'b0;
    end else if (m_own < 0) begin
`ifdef ARB_FIXED_PRIO_EN
      if (r0_req)      new_own = 0;
      else if (r1_req) new_own = 1;
`else
      if (r0_req && r1_req) new_own = m_pref;
      else if (r0_req)      new_own = 0;
      else if (r1_req)      new_own = 1;
`endif
    end else begin
      o    = m_own;
      oreq = (o == 0) ? r0_req : r1_req;
      oth  = (o == 0) ? r1_req : r0_req;
      if (!oreq) new_own = -1;
`ifdef ARB_FIXED_PRIO_EN
      else if (o == 1 && oth && (m_run + acc >= BM)) new_own = 0;
`else
      else if (oth && (m_run + acc >= BM)) new_own = 1 - o;
`endif
    end
    if (m_own >= 0 && new_own != m_own) m_pref = 1 - m_own;
    if (new_own != m_own || new_boot != m_in_boot) m_run = 0;
    else if (m_run < BM) m_run = m_run + acc;
    m_own     = new_own;
    m_in_boot = new_boot;
    m_tick++;
    while (m_q.size() > 0 && m_q[0].due < m_tick) void'(m_q.pop_front());
    if (m_q.size() > 0 && m_q[0].due == m_tick) m_rd = m_q[0].data;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick_cycle();
    #1;
    check_outputs();
    obs_acc0 = r0_gnt & r0_req & ce;
    obs_acc1 = r1_gnt & r1_req & ce;
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check("rst_rd_data", 32'(rd_data), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rnd(output logic rw, output logic [ADR_W-1:0] adr, output logic [DAT_W-1:0] din);
    rw  = ($urandom_range(0, 2) == 0);
    adr = ADR_W'($urandom);
    din = DAT_W'($urandom);
  endtask

  initial begin
    int cur, run, first, k, rem0, rem1, boot_left;
    bit seen;
    rst = 1'b1; ce = 1'b1; boot = 1'b1; mem_init = 1'b1;
    bl_rw = 1'b0; bl_en = 1'b0; bl_adr = '0; bl_din = '0;
    r0_req = 1'b0; r0_rw = 1'b0; r0_adr = '0; r0_din = '0;
    r1_req = 1'b0; r1_rw = 1'b0; r1_adr = '0; r1_din = '0;
    obs_acc0 = 1'b0; obs_acc1 = 1'b0;
    m_tick = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
    @(negedge clk);
    do_reset();
    mem_init = 1'b0;

    // Boot loader pass-through write.
    bl_en = 1'b1; bl_rw = 1'b1; bl_adr = 6'd5; bl_din = 16'hBEEF;
    #1;
    check("t1_ram_adr", 32'(ram_adr), 32'd5);
    check("t1_ram_in", 32'(ram_in), 32'hBEEF);
    check("t1_ram_rw", 32'(ram_rw), 32'd1);
    check("t1_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    tick_cycle();

    // Single read by requester 0.
    boot = 1'b0; bl_en = 1'b0; bl_rw = 1'b0;
    r0_req = 1'b1; r0_rw = 1'b0; r0_adr = 6'd3;
    tick_cycle();                 // BOOT -> IDLE
    tick_cycle();                 // IDLE -> GRANT0
    check("t2_gnt", 32'(r0_gnt), 32'd1);
    tick_cycle();                 // accepted
    r0_req = 1'b0;
    check("t2_rvalid_early", 32'(r0_rvalid), 32'd0);
    tick_cycle();
    check("t2_rvalid", 32'(r0_rvalid), 32'd1);
    check("t2_rd_data", 32'(rd_data), 32'h1234);
    tick_cycle();

    // Both requesting continuously: bursts of BM alternating owners.
    cur = -1; run = 0; first = -1;
    r0_req = 1'b1; r1_req = 1'b1; r0_rw = 1'b0; r1_rw = 1'b0;
    for (int c = 0; c < 60; c++) begin
      r0_adr = ADR_W'($urandom); r1_adr = ADR_W'($urandom);
      tick_cycle();
      if (obs_acc0 || obs_acc1) begin
        k = obs_acc1 ? 1 : 0;
        if (first < 0) first = k;
        if (k == cur) run++;
        else begin
`ifndef ARB_FIXED_PRIO_EN
          if (cur >= 0) check("t3_burst_len", 32'(run), 32'(BM));
`endif
          cur = k; run = 1;
        end
      end
    end
`ifndef ARB_FIXED_PRIO_EN
    check("t4_first_owner", 32'(first), 32'd1);
`endif

    // Boot takes over in the middle of a requester 1 burst.
    k = 0;
    while (!r1_gnt && k < 20) begin tick_cycle(); k++; end
    check("t5_in_grant1", 32'(r1_gnt), 32'd1);
    r0_req = 1'b0; r1_rw = 1'b0;
    tick_cycle();
    boot = 1'b1;
    tick_cycle();
    check("t5_gnt_drop", 32'(r1_gnt), 32'd0);
    check("t5_pending_rvalid", 32'(r1_rvalid), 32'd1);
    boot = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 6) begin tick_cycle(); seen = r1_gnt; k++; end
    check("t5_regrant", 32'(seen), 32'd1);

    // Clock enable low while granted: everything frozen.
    r1_req = 1'b0; r0_req = 1'b1; r0_rw = 1'b0; r0_adr = 6'd9;
    k = 0;
    while (!r0_gnt && k < 8) begin tick_cycle(); k++; end
    check("t6_in_grant0", 32'(r0_gnt), 32'd1);
    tick_cycle();
    ce = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick_cycle();
      check("t6_gnt_hold", 32'(r0_gnt), 32'd1);
    end
    ce = 1'b1;
    r0_req = 1'b0;
    tick_cycle();
    tick_cycle();

    // Randomized traffic with a mid-run reset.
    rem0 = 0; rem1 = 0; boot_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        r0_req = 1'b0; r1_req = 1'b0; boot = 1'b0; bl_en = 1'b0;
        rem0 = 0; rem1 = 0; boot_left = 0;
        obs_acc0 = 1'b0; obs_acc1 = 1'b0;
        do_reset();
      end
      ce = ($urandom_range(0, 9) != 0);
      if (boot_left > 0) boot_left--;
      else if ($urandom_range(0, 59) == 0) boot_left = $urandom_range(1, 4);
      boot  = (boot_left > 0);
      bl_en = $urandom_range(0, 1) == 1;
      rnd(bl_rw, bl_adr, bl_din);
      if (obs_acc0) begin rem0--; rnd(r0_rw, r0_adr, r0_din); end
      if (obs_acc1) begin rem1--; rnd(r1_rw, r1_adr, r1_din); end
      if (rem0 == 0 && $urandom_range(0, 3) == 0) begin
        rem0 = $urandom_range(1, 20); rnd(r0_rw, r0_adr, r0_din);
      end
      if (rem1 == 0 && $urandom_range(0, 3) == 0) begin
        rem1 = $urandom_range(1, 20); rnd(r1_rw, r1_adr, r1_din);
      end
      r0_req = (rem0 > 0);
      r1_req = (rem1 > 0);
      tick_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
